// File: rtl/spi_pkg.sv
// Shared frame layout constants and types for the SPI responder that bridges frames to a
// register bank.
package spi_pkg;

  localparam int unsigned FRAME_BITS  = 24;
  localparam int unsigned RW_BIT      = 23;
  localparam int unsigned ADDR_LSB    = 9;
  localparam int unsigned DATA_LSB    = 1;
  localparam int unsigned RD_SLOT_MSB = 7;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    RX_HDR,
    RX_DATA,
    DONE,
    WAIT_CS
  } slave_state_t;

  // The sample edge is the rising edge exactly when CPOL equals CPHA.
  function automatic logic sample_on_rise(spi_mode_t m);
    return m.cpol == m.cpha;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous SPI pin, reset to the pin's idle level.
module spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI responder: oversamples the SPI pins, decodes 24-bit R/W + address + data frames into
// single-cycle register strobes and returns read data on MISO.
module spi_slave_regif
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAME_BITS  = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  csb,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [1:0]            spi_mode,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(FRAME_BITS - ADDR_LSB);
  localparam logic [CNT_W-1:0] CNT_RD0  = CNT_W'(FRAME_BITS - 1 - RD_SLOT_MSB);

  logic sclk_s, csb_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .rst(rst), .d(csb), .q(csb_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  slave_state_t          state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Holds frame bits 23..1; the pad bit is never shifted in.
  logic [FRAME_BITS-2:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  rd_frame_q, rd_frame_d;
  logic                  miso_q, miso_d;
  logic                  sclk_prev_q, csb_prev_q, cap_q;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic sclk_rise, sclk_fall, csb_fall, in_rx, samp_edge, drv_edge, sample;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;
  assign in_rx     = (state_q == RX_HDR) || (state_q == RX_DATA);
  assign samp_edge = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;
  assign drv_edge  = sample_on_rise(mode_q) ? sclk_fall : sclk_rise;
  assign sample    = in_rx & samp_edge;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rd_frame_d = rd_frame_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (sample) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q != CNT_LAST) begin
        rx_d = {rx_q[FRAME_BITS-3:0], mosi_s};
      end
    end

    if (cap_q) begin
      tx_d = reg_rd_data;
    end

    // Read-data slots open once the first 16 bits are in; every other drive edge idles MISO.
    if (in_rx && drv_edge) begin
      if (rd_frame_q && cnt_q >= CNT_RD0 && cnt_q < CNT_FULL) begin
        miso_d = tx_q[DATA_WIDTH-1];
        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        miso_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_d    = RX_HDR;
          mode_d     = spi_mode_t'(spi_mode);
          cnt_d      = '0;
          rx_d       = '0;
          rd_frame_d = 1'b0;
          miso_d     = 1'b0;
        end
      end
      RX_HDR: begin
        if (sample && cnt_d == CNT_HDR) begin
          state_d    = RX_DATA;
          addr_d     = rx_d[ADDR_WIDTH-1:0];
          rd_frame_d = ~rx_d[RW_BIT-ADDR_LSB];
          rd_en_d    = ~rx_d[RW_BIT-ADDR_LSB];
        end
      end
      RX_DATA: begin
        if (sample && cnt_d == CNT_FULL) begin
          state_d = DONE;
          done_d  = 1'b1;
          miso_d  = 1'b0;
          if (rx_q[FRAME_BITS-2]) begin
            wr_en_d = 1'b1;
            wdata_d = rx_q[DATA_LSB-1 +: DATA_WIDTH];
          end
        end
      end
      DONE:    state_d = WAIT_CS;
      WAIT_CS: state_d = WAIT_CS;
      default: state_d = IDLE;
    endcase

    // CSB release is evaluated after any coincident sample, so a 24th bit still completes.
    if (csb_s && state_q != IDLE) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      if (cnt_d != '0 && cnt_d != CNT_FULL) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_frame_q  <= 1'b0;
      miso_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b1;
      cap_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_frame_q  <= rd_frame_d;
      miso_q      <= miso_d;
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
      cap_q       <= rd_en_q;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = ~csb_s;
  assign reg_wr_en  = wr_en_q;
  assign reg_rd_en  = rd_en_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: a bit-banged SPI master plus a model register bank.
module tb_spi_slave_regif;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        csb = 1'b1;
  logic        mosi = 1'b0;
  logic [1:0]  spi_mode = 2'b00;
  logic [7:0]  reg_rd_data = 8'h00;
  logic        miso, miso_oe, reg_wr_en, reg_rd_en, frame_done, frame_err;
  logic [13:0] reg_addr;
  logic [7:0]  reg_wdata;

  always #5 clk = ~clk;

  spi_slave_regif dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .spi_mode(spi_mode), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rd_data(reg_rd_data),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;

  // Model register bank with two preset locations, plus strobe logs.
  logic [7:0]  bank [0:16383];
  logic [13:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [13:0] rd_addr_q[$];
  int done_cnt = 0, err_cnt = 0, wr_nodone = 0;

  always @(posedge clk) begin
    if (rst) begin
      bank[14'h3FFF] <= 8'h5A;
      bank[14'h0001] <= 8'hC3;
    end else begin
      if (reg_wr_en) bank[reg_addr] <= reg_wdata;
      if (reg_rd_en) reg_rd_data <= bank[reg_addr];
    end
  end

  always @(posedge clk) begin
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
      if (!frame_done) wr_nodone <= wr_nodone + 1;
    end
    if (reg_rd_en) rd_addr_q.push_back(reg_addr);
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [23:0] wr_word(input logic [13:0] a, input logic [7:0] d);
    return {1'b1, a, d, 1'b0};
  endfunction

  function automatic logic [23:0] rd_word(input logic [13:0] a);
    return {1'b0, a, 8'h00, 1'b0};
  endfunction

  // One CSB-low frame of nbits SCLK pulses; half is the SCLK half-period in clk cycles.
  task automatic spi_xfer(input logic [1:0] mode, input int half, input logic [23:0] word,
                          input int nbits, input bit hold_cs, output logic [23:0] rx);
    logic cpol, cpha;
    int b;
    cpol = mode[1];
    cpha = mode[0];
    rx = '0;
    @(negedge clk);
    spi_mode = mode;
    sclk = cpol;
    csb = 1'b1;
    mosi = 1'b0;
    wait_clks(half);
    csb = 1'b0;
    if (!cpha) mosi = word[23];
    wait_clks(half);
    for (int i = 0; i < nbits; i++) begin
      b = 23 - i;
      sclk = ~cpol;
      if (cpha) mosi = (b >= 0) ? word[b] : 1'b0;
      else if (b >= 0) rx[b] = miso;
      wait_clks(half);
      sclk = cpol;
      if (cpha) begin
        if (b >= 0) rx[b] = miso;
      end else begin
        mosi = (b >= 1) ? word[b-1] : 1'b0;
      end
      wait_clks(half);
    end
    if (!hold_cs) begin
      csb = 1'b1;
      mosi = 1'b0;
      wait_clks(half);
    end
  endtask

  int n_wr0, n_rd0, done0, err0;
  task automatic snap();
    n_wr0 = wr_addr_q.size();
    n_rd0 = rd_addr_q.size();
    done0 = done_cnt;
    err0  = err_cnt;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rx;
    int halves [2];
    halves[0] = 4;
    halves[1] = 9;

    // Reset state
    wait_clks(5);
    check("rst_outputs", {24'h0, miso, miso_oe, reg_wr_en, reg_rd_en, frame_done, frame_err, 2'b00},
          32'h0);
    check("rst_addr_wdata", {10'h0, reg_addr, reg_wdata}, 32'h0);
    rst = 1'b0;
    wait_clks(5);
    check("idle_miso_oe", {31'h0, miso_oe}, 32'h0);

    // Mode 0 write 0x0123 <- 0xA5
    snap();
    spi_xfer(2'b00, 4, wr_word(14'h0123, 8'hA5), 24, 1'b0, rx);
    wait_clks(8);
    check("m0_wr_count", 32'(wr_addr_q.size() - n_wr0), 32'd1);
    check("m0_wr_addr", 32'(wr_addr_q[n_wr0]), 32'h0123);
    check("m0_wr_data", 32'(wr_data_q[n_wr0]), 32'hA5);
    check("m0_done", 32'(done_cnt - done0), 32'd1);
    check("m0_no_rd", 32'(rd_addr_q.size() - n_rd0), 32'd0);
    check("m0_addr_held", 32'(reg_addr), 32'h0123);

    // Mode 3 read 0x3FFF, bank holds 0x5A
    snap();
    spi_xfer(2'b11, 5, rd_word(14'h3FFF), 24, 1'b0, rx);
    wait_clks(8);
    check("m3_rd_count", 32'(rd_addr_q.size() - n_rd0), 32'd1);
    check("m3_rd_addr", 32'(rd_addr_q[n_rd0]), 32'h3FFF);
    check("m3_rd_data", 32'(rx[7:0]), 32'h5A);
    check("m3_no_wr", 32'(wr_addr_q.size() - n_wr0), 32'd0);
    check("m3_done", 32'(done_cnt - done0), 32'd1);

    // All modes, two prescales: write then read back
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 2; p++) begin
        snap();
        spi_xfer(2'(m), halves[p], wr_word(14'h2AAA, 8'h3C), 24, 1'b0, rx);
        spi_xfer(2'(m), halves[p], rd_word(14'h2AAA), 24, 1'b0, rx);
        wait_clks(8);
        check($sformatf("loop_wr_data_m%0d_p%0d", m, halves[p]), 32'(wr_data_q[n_wr0]), 32'h3C);
        check($sformatf("loop_rd_data_m%0d_p%0d", m, halves[p]), 32'(rx[7:0]), 32'h3C);
        check($sformatf("loop_counts_m%0d_p%0d", m, halves[p]),
              32'((wr_addr_q.size() - n_wr0) * 16 + (rd_addr_q.size() - n_rd0) * 4
                  + (err_cnt - err0)), 32'h14);
      end
    end

    // CSB released after 10 bits
    snap();
    spi_xfer(2'b00, 4, wr_word(14'h0456, 8'h77), 10, 1'b0, rx);
    wait_clks(8);
    check("abort_err", 32'(err_cnt - err0), 32'd1);
    check("abort_no_strobe", 32'((wr_addr_q.size() - n_wr0) + (rd_addr_q.size() - n_rd0)), 32'd0);
    check("abort_no_done", 32'(done_cnt - done0), 32'd0);
    snap();
    spi_xfer(2'b00, 4, wr_word(14'h0456, 8'h77), 24, 1'b0, rx);
    wait_clks(8);
    check("after_abort_wr_addr", 32'(wr_addr_q[n_wr0]), 32'h0456);
    check("after_abort_wr_data", 32'(wr_data_q[n_wr0]), 32'h77);
    check("after_abort_no_err", 32'(err_cnt - err0), 32'd0);

    // Reset in the middle of a read frame
    snap();
    spi_xfer(2'b00, 4, rd_word(14'h0001), 12, 1'b1, rx);
    check("mid_frame_oe", {31'h0, miso_oe}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {24'h0, miso, miso_oe, reg_wr_en, reg_rd_en, frame_done, frame_err, 2'b00},
          32'h0);
    check("midrst_addr_wdata", {10'h0, reg_addr, reg_wdata}, 32'h0);
    csb = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    check("midrst_no_strobe", 32'((wr_addr_q.size() - n_wr0) + (rd_addr_q.size() - n_rd0)
                                  + (err_cnt - err0) + (done_cnt - done0)), 32'd0);
    snap();
    spi_xfer(2'b01, 4, rd_word(14'h0001), 24, 1'b0, rx);
    wait_clks(8);
    check("post_rst_rd_addr", 32'(rd_addr_q[n_rd0]), 32'h0001);
    check("post_rst_rd_data", 32'(rx[7:0]), 32'hC3);
    check("post_rst_done", 32'(done_cnt - done0), 32'd1);

    // Back-to-back writes with CSB high for two half-periods
    snap();
    spi_xfer(2'b10, 4, wr_word(14'h1111, 8'h11), 24, 1'b0, rx);
    spi_xfer(2'b10, 4, wr_word(14'h2222, 8'h22), 24, 1'b0, rx);
    wait_clks(8);
    check("b2b_count", 32'(wr_addr_q.size() - n_wr0), 32'd2);
    check("b2b_first", {10'h0, wr_addr_q[n_wr0], wr_data_q[n_wr0]}, {10'h0, 14'h1111, 8'h11});
    check("b2b_second", {10'h0, wr_addr_q[n_wr0+1], wr_data_q[n_wr0+1]}, {10'h0, 14'h2222, 8'h22});

    // 30 SCLK pulses in one frame
    snap();
    spi_xfer(2'b00, 4, wr_word(14'h0777, 8'h99), 30, 1'b0, rx);
    wait_clks(8);
    check("long_wr_count", 32'(wr_addr_q.size() - n_wr0), 32'd1);
    check("long_wr_data", 32'(wr_data_q[n_wr0]), 32'h99);
    check("long_done_err", 32'((done_cnt - done0) * 16 + (err_cnt - err0)), 32'h10);

    check("wr_with_done", 32'(wr_nodone), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
